raytracing_scheduler: RTL and testbench

Frame-level sequencer for the bank of `Raytracing_Worker` instances. Per scanline:
- computes the row-shared operands `doty_r`, `pixel_y_sqrd` and `sphere_y_sqrd`;
- activates all workers together and waits for them to finish;
- drains their colour buffers, in pixel order, to the framebuffer write port.

It sits between the frame controller (`start` / `frame_done`) and the worker array plus the framebuffer.

---
 rtl/raytracing_scheduler_if.sv | 14 +
 rtl/raytracing_scheduler.sv | 265 ++++++++++++++++++++++++++
 tb/tb_raytracing_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/raytracing_scheduler_if.sv
// Framebuffer write port driven by the raytracing scheduler.
// A pixel transfers on every cycle where wr_valid and wr_ready are both high.
interface raytracing_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/raytracing_scheduler.sv
// Per-scanline sequencer for the raytracing worker bank: row operands, worker launch, in-order framebuffer drain.
// Define RT_SCHED_TIMEOUT_EN to build the LAUNCH/RUN watchdog (timeout_err_o, zero-filled row on expiry).
`ifndef PX_Y_SQRD_B
`define PX_Y_SQRD_B 16
`endif
`ifndef S_Y_SQRD_B
`define S_Y_SQRD_B 28
`endif

package Types;
    localparam int FP_B = 4;
    typedef logic [11:0] Color;
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
        logic signed [15:0] r;
    } Sphere;
endpackage

module raytracing_scheduler #(
    parameter int N_WORKERS        = 8,
    parameter int JOBS_SUBDIVISION = 40,
    parameter int SCREEN_W         = 320,
    parameter int SCREEN_H         = 240,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start_i,
    input  Types::Sphere                                       sphere_i,
    output logic                                               busy_o,
    output logic                                               frame_done_o,
    output logic                                               timeout_err_o,
    output logic                                               worker_activate_o,
    input  logic [N_WORKERS-1:0]                               worker_busy_i,
    output logic [N_WORKERS-1:0][11:0]                         pixel_start_x_o,
    output Types::Sphere                                       sphere_out_o,
    output logic signed [21:0]                                 doty_r_o,
    output logic [`PX_Y_SQRD_B-1:0]                            pixel_y_sqrd_o,
    output logic [`S_Y_SQRD_B-1:0]                             sphere_y_sqrd_o,
    input  Types::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0]  worker_buffer_i,
    raytracing_scheduler_if.master                             fb
);
    localparam int W_W   = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int K_W   = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
    localparam int ROW_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

    if (N_WORKERS * JOBS_SUBDIVISION != SCREEN_W) begin : g_bad_split
        $error("N_WORKERS*JOBS_SUBDIVISION must equal SCREEN_W");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_NEXT   = 3'd5
    } state_e;

    state_e                       state_q, state_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [W_W-1:0]               w_q, w_d;
    logic [K_W-1:0]               k_q, k_d;
    logic [16:0]                  addr_q, addr_d;
    Types::Sphere                 sphere_q, sphere_d;
    logic signed [21:0]           doty_q, doty_d;
    logic [`PX_Y_SQRD_B-1:0]      pys_q, pys_d;
    logic [`S_Y_SQRD_B-1:0]       sys_q, sys_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         act_q, act_d;
    logic                         valid_q, valid_d;
    Types::Color                  data_q, data_d;
    logic                         zero_q, zero_d;
    logic [N_WORKERS-1:0][11:0]   psx_q, psx_d;
    logic signed [12:0]           y_s;
    logic                         accept_s;

`ifdef RT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         terr_q, terr_d;
`endif

    assign accept_s = valid_q && fb.wr_ready;

    // Next-state, row operand and drain-walk logic.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        w_d      = w_q;
        k_d      = k_q;
        addr_d   = addr_q;
        sphere_d = sphere_q;
        doty_d   = doty_q;
        pys_d    = pys_q;
        sys_d    = sys_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        y_s      = $signed(13'(SCREEN_H / 2)) - $signed(13'(row_q));
        for (int w = 0; w < N_WORKERS; w++) begin
            psx_d[w] = 12'(w - SCREEN_W / 2);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sphere_d = sphere_i;
                    row_d    = {ROW_W{1'b0}};
                    addr_d   = 17'd0;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SETUP: begin
                pys_d   = `PX_Y_SQRD_B'(16'(y_s) * 16'(y_s));
                doty_d  = 22'(22'(y_s) * 22'(sphere_q.y));
                sys_d   = `S_Y_SQRD_B'((32'(sphere_q.y) * 32'(sphere_q.y)) >>> Types::FP_B);
                zero_d  = 1'b0;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (&worker_busy_i) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_RUN: begin
                if (~|worker_busy_i) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // w is the inner index, so x = k*N + w grows by one per accepted pixel.
                if (accept_s) begin
                    addr_d = addr_q + 17'd1;
                    if (w_q == W_W'(N_WORKERS - 1)) begin
                        w_d = {W_W{1'b0}};
                        if (k_q == K_W'(JOBS_SUBDIVISION - 1)) begin
                            k_d     = {K_W{1'b0}};
                            state_d = S_NEXT;
                        end else begin
                            k_d = k_q + K_W'(1);
                        end
                    end else begin
                        w_d = w_q + W_W'(1);
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            S_NEXT: begin
                if (row_q == ROW_W'(SCREEN_H - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_SETUP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef RT_SCHED_TIMEOUT_EN
        terr_d = terr_q;
        cnt_d  = (state_q == S_LAUNCH || state_q == S_RUN) ? cnt_q + CNT_W'(1) : {CNT_W{1'b0}};
        if ((state_q == S_LAUNCH || state_q == S_RUN) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            terr_d  = 1'b1;
            zero_d  = 1'b1;
            state_d = S_DRAIN;
        end else begin
            terr_d  = terr_q;
        end
`endif

        act_d   = (state_d == S_LAUNCH) || (state_d == S_RUN);
        valid_d = (state_d == S_DRAIN);
        if (state_d == S_DRAIN && !zero_d) begin
            data_d = worker_buffer_i[w_d][k_d];
        end else begin
            data_d = 12'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= {ROW_W{1'b0}};
            w_q      <= {W_W{1'b0}};
            k_q      <= {K_W{1'b0}};
            addr_q   <= 17'd0;
            sphere_q <= '0;
            doty_q   <= 22'sd0;
            pys_q    <= {`PX_Y_SQRD_B{1'b0}};
            sys_q    <= {`S_Y_SQRD_B{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            act_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= 12'd0;
            zero_q   <= 1'b0;
            psx_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            w_q      <= w_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            sphere_q <= sphere_d;
            doty_q   <= doty_d;
            pys_q    <= pys_d;
            sys_q    <= sys_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            act_q    <= act_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            psx_q    <= psx_d;
        end
    end

`ifdef RT_SCHED_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err_o = terr_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign busy_o            = busy_q;
    assign frame_done_o      = done_q;
    assign worker_activate_o = act_q;
    assign pixel_start_x_o   = psx_q;
    assign sphere_out_o      = sphere_q;
    assign doty_r_o          = doty_q;
    assign pixel_y_sqrd_o    = pys_q;
    assign sphere_y_sqrd_o   = sys_q;
    assign fb.wr_valid       = valid_q;
    assign fb.wr_addr        = addr_q;
    assign fb.wr_data        = data_q;
endmodule

// File: tb/tb_raytracing_scheduler.sv
// Directed bench for raytracing_scheduler on a 4x2 screen with two behavioural workers.
`ifndef PX_Y_SQRD_B
`define PX_Y_SQRD_B 16
`endif
`ifndef S_Y_SQRD_B
`define S_Y_SQRD_B 28
`endif

module tb_raytracing_scheduler;
    localparam int N = 2, J = 2, W = 4, H = 2, TMO = 16;

    logic clk = 1'b0;
    logic rst, start;
    Types::Sphere sphere;
    logic busy, frame_done, timeout_err, worker_activate;
    logic [N-1:0] worker_busy = '0;
    logic [N-1:0][11:0] pixel_start_x;
    Types::Sphere sphere_out;
    logic signed [21:0] doty_r;
    logic [`PX_Y_SQRD_B-1:0] pixel_y_sqrd;
    logic [`S_Y_SQRD_B-1:0] sphere_y_sqrd;
    Types::Color [N-1:0][J-1:0] wbuf;

    raytracing_scheduler_if fb_if ();

    raytracing_scheduler #(
        .N_WORKERS(N), .JOBS_SUBDIVISION(J), .SCREEN_W(W), .SCREEN_H(H), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .sphere_i(sphere),
        .busy_o(busy), .frame_done_o(frame_done), .timeout_err_o(timeout_err),
        .worker_activate_o(worker_activate), .worker_busy_i(worker_busy),
        .pixel_start_x_o(pixel_start_x), .sphere_out_o(sphere_out), .doty_r_o(doty_r),
        .pixel_y_sqrd_o(pixel_y_sqrd), .sphere_y_sqrd_o(sphere_y_sqrd),
        .worker_buffer_i(wbuf), .fb(fb_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit stuck = 1'b0;
    bit bp_mode = 1'b0;

    // Behavioural workers: busy for 5 cycles after activate, then READY until activate drops.
    int  wcnt [N];
    bit  wdone [N];
    always @(negedge clk) begin
        for (int w = 0; w < N; w++) begin
            if (rst || !worker_activate) begin
                worker_busy[w] = 1'b0;
                wdone[w] = 1'b0;
            end else if (stuck && w == N - 1) begin
                worker_busy[w] = 1'b1;
            end else if (!worker_busy[w] && !wdone[w]) begin
                worker_busy[w] = 1'b1;
                wcnt[w] = 5;
            end else if (worker_busy[w]) begin
                wcnt[w] = wcnt[w] - 1;
                if (wcnt[w] == 0) begin
                    worker_busy[w] = 1'b0;
                    wdone[w] = 1'b1;
                end
            end
        end
    end

    // Framebuffer sink: drives wr_ready, logs accepted writes, drain lengths and stall stability.
    logic [16:0] wr_addr_log [256];
    logic [11:0] wr_data_log [256];
    int n_wr = 0, n_done = 0, n_drain = 0, drain_len = 0, bp_idx = 0;
    int drain_log [64];
    int act_len = 0, act_last = 0;
    int stab_checks = 0, stab_bad = 0;
    bit stall_prev = 1'b0;
    logic [16:0] stall_addr;
    logic [11:0] stall_data;
    logic [3:0] bp_pat = 4'b1001;
    always @(negedge clk) begin
        if (fb_if.wr_valid) begin
            fb_if.wr_ready = bp_mode ? bp_pat[bp_idx % 4] : 1'b1;
            bp_idx++;
        end else begin
            fb_if.wr_ready = 1'b0;
            bp_idx = 0;
        end
        if (stall_prev && fb_if.wr_valid) begin
            stab_checks++;
            if (fb_if.wr_addr !== stall_addr || fb_if.wr_data !== stall_data) stab_bad++;
        end
        stall_prev = fb_if.wr_valid && !fb_if.wr_ready;
        stall_addr = fb_if.wr_addr;
        stall_data = fb_if.wr_data;
        if (fb_if.wr_valid && fb_if.wr_ready && n_wr < 256) begin
            wr_addr_log[n_wr] = fb_if.wr_addr;
            wr_data_log[n_wr] = fb_if.wr_data;
            n_wr++;
        end
        if (fb_if.wr_valid) begin
            drain_len++;
        end else if (drain_len > 0) begin
            if (n_drain < 64) drain_log[n_drain] = drain_len;
            n_drain++;
            drain_len = 0;
        end
        if (frame_done) n_done++;
        if (worker_activate) begin
            act_len++;
        end else if (act_len > 0) begin
            act_last = act_len;
            act_len = 0;
        end
    end

    typedef struct { logic [16:0] addr; logic [11:0] data; } wr_vec_t;
    wr_vec_t vec [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (busy && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check({nm, "_idle_bound"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_run(input string nm);
        int i = 0;
        while (!(worker_activate && (&worker_busy)) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check({nm, "_run_bound"}, 64'(worker_activate && (&worker_busy)), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input int base, input bit zero);
        check({nm, "_nwr"}, 64'(n_wr - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_addr%0d", nm, i), 64'(wr_addr_log[(base + i) % 256]), 64'(vec[i].addr));
            check($sformatf("%s_data%0d", nm, i), 64'(wr_data_log[(base + i) % 256]),
                  zero ? 64'd0 : 64'(vec[i].data));
        end
    endtask

    initial begin
        int b_wr, b_done, b_drain;
        vec[0] = '{17'd0, 12'h000};  vec[1] = '{17'd1, 12'h010};
        vec[2] = '{17'd2, 12'h001};  vec[3] = '{17'd3, 12'h011};
        vec[4] = '{17'd4, 12'h000};  vec[5] = '{17'd5, 12'h010};
        vec[6] = '{17'd6, 12'h001};  vec[7] = '{17'd7, 12'h011};
        for (int w = 0; w < N; w++)
            for (int k = 0; k < J; k++)
                wbuf[w][k] = 12'(w * 16 + k);
        sphere = '{x: 16'sd3, y: 16'sd100, z: 16'sd50, r: 16'sd20};
        rst = 1'b1;
        start = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({busy, frame_done, worker_activate, timeout_err, fb_if.wr_valid}), 64'd0);
        check("reset_wr", 64'({fb_if.wr_addr, fb_if.wr_data}), 64'd0);
        check("reset_ops", 64'({doty_r, pixel_y_sqrd, sphere_y_sqrd}), 64'd0);
        check("reset_sphere_out", 64'(sphere_out), 64'd0);
        check("reset_start_x", 64'(pixel_start_x), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("start_x", 64'(pixel_start_x), 64'h0000_0000_00FF_FFFE);

        // Frame 1: free-running sink.
        b_wr = n_wr; b_done = n_done; b_drain = n_drain;
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        @(negedge clk);
        check("doty_r_row0", 64'(doty_r), 64'd100);
        check("pixel_y_sqrd_row0", 64'(pixel_y_sqrd), 64'd1);
        check("sphere_y_sqrd", 64'(sphere_y_sqrd), 64'd625);
        check("sphere_out", 64'(sphere_out), 64'(sphere));
        check("activate_launch", 64'(worker_activate), 64'd1);
        wait_idle("f1");
        check_frame("f1", b_wr, 1'b0);
        check("f1_done_count", 64'(n_done - b_done), 64'd1);
        check("f1_drain_rows", 64'(n_drain - b_drain), 64'd2);
        check("f1_drain_len0", 64'(drain_log[b_drain % 64]), 64'd4);
        check("f1_drain_len1", 64'(drain_log[(b_drain + 1) % 64]), 64'd4);
        check("f1_timeout_err", 64'(timeout_err), 64'd0);

        // Frame 2: wr_ready pattern 1,0,0,1 stalls each row for 4 cycles.
        bp_mode = 1'b1;
        b_wr = n_wr; b_done = n_done; b_drain = n_drain;
        pulse_start();
        wait_idle("f2");
        bp_mode = 1'b0;
        check_frame("f2", b_wr, 1'b0);
        check("f2_done_count", 64'(n_done - b_done), 64'd1);
        check("f2_drain_len0", 64'(drain_log[b_drain % 64]), 64'd8);
        check("f2_drain_len1", 64'(drain_log[(b_drain + 1) % 64]), 64'd8);
        check("f2_stall_seen", 64'(stab_checks > 0), 64'd1);
        check("f2_stall_stable", 64'(stab_bad), 64'd0);

        // Frame 3: a second start during RUN is ignored.
        b_wr = n_wr; b_done = n_done;
        pulse_start();
        wait_run("f3");
        pulse_start();
        wait_idle("f3");
        check_frame("f3", b_wr, 1'b0);
        check("f3_done_count", 64'(n_done - b_done), 64'd1);

        // Reset during RUN abandons the frame; a new start restarts at address 0.
        b_wr = n_wr; b_done = n_done;
        pulse_start();
        wait_run("rst");
        rst = 1'b1;
        @(negedge clk);
        check("rst_run_outputs", 64'({worker_activate, fb_if.wr_valid, busy}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_done", 64'(n_done - b_done), 64'd0);
        check("rst_no_writes", 64'(n_wr - b_wr), 64'd0);
        b_wr = n_wr; b_done = n_done;
        pulse_start();
        wait_idle("f4");
        check_frame("f4", b_wr, 1'b0);
        check("f4_done_count", 64'(n_done - b_done), 64'd1);

`ifdef RT_SCHED_TIMEOUT_EN
        // One worker stuck busy: each row times out after 16 cycles and is written as zeros.
        stuck = 1'b1;
        b_wr = n_wr; b_done = n_done;
        pulse_start();
        wait_idle("tmo");
        stuck = 1'b0;
        check("tmo_err", 64'(timeout_err), 64'd1);
        check("tmo_act_len", 64'(act_last), 64'd16);
        check_frame("tmo", b_wr, 1'b1);
        check("tmo_done_count", 64'(n_done - b_done), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired, want finished");
        $fatal(1);
    end
endmodule
